// File: rtl/param_counter.sv
// ---------------------------------------------------------------------------
// param_counter
//   Modulo-(MAX_COUNT+1) up/down counter with count enable, a prescaler,
//   synchronous clear, parallel load (saturating at MAX_COUNT), a registered
//   one-cycle terminal-count pulse on wrap and a sticky wrap flag.
//
// Ports
//   clk   in   system clock, all state updates on the rising edge
//   rs    in   asynchronous active-low reset
//   en    in   count enable (gates prescaler and stepping)
//   up    in   direction, 1 = up, 0 = down, sampled at each step
//   clr   in   synchronous clear (highest priority)
//   load  in   synchronous parallel load
//   d     in   load value, saturated to MAX_COUNT
//   q     out  current count, registered
//   tc    out  one-cycle pulse on the cycle after a wrap step
//   ovf   out  sticky wrap flag, cleared only by clr or rs
// ---------------------------------------------------------------------------
module param_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int PRESCALE  = 1,
    parameter int PS_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    logic             step;
    logic [WIDTH-1:0] q_reg;
    logic             tc_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] q_up;
    logic [WIDTH-1:0] q_down;
    logic [WIDTH-1:0] q_load;
    logic             wrap;

    // -----------------------------------------------------------------------
    // Prescaler. With PRESCALE == 1 no register exists at all and every
    // enabled cycle is a step. Otherwise the phase counter runs 0..PRESCALE-1
    // on enabled cycles and the step coincides with the terminal phase.
    // clr and load both restart the phase so the next step needs a full
    // PRESCALE enabled cycles.
    // -----------------------------------------------------------------------
    generate
        if (PRESCALE <= 1) begin : g_no_prescale
            assign step = en;
        end else begin : g_prescale
            localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);
            localparam logic [PS_WIDTH-1:0] PS_ONE  = PS_WIDTH'(1);

            logic [PS_WIDTH-1:0] ps_reg;

            always_ff @(posedge clk or negedge rs) begin
                if (!rs) begin
                    ps_reg <= '0;
                end else if (clr || load) begin
                    ps_reg <= '0;
                end else if (en) begin
                    if (ps_reg == PS_LAST) begin
                        ps_reg <= '0;
                    end else begin
                        ps_reg <= ps_reg + PS_ONE;
                    end
                end
            end

            assign step = en && (ps_reg == PS_LAST);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-value candidates. Wrap is decided on the current count and the
    // direction sampled on this very edge, so a direction flip exactly on a
    // step edge already uses the new direction.
    // -----------------------------------------------------------------------
    always_comb begin
        q_up   = (q_reg == MAX_Q) ? '0 : q_reg + ONE_Q;
        q_down = (q_reg == '0) ? MAX_Q : q_reg - ONE_Q;
        wrap   = up ? (q_reg == MAX_Q) : (q_reg == '0);
        q_load = (d > MAX_Q) ? MAX_Q : d;
    end

    // Priority: clr > load > step > hold. tc is a pulse, so every branch
    // other than a wrapping step drives it low.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            q_reg   <= '0;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else if (clr) begin
            q_reg   <= '0;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else if (load) begin
            q_reg  <= q_load;
            tc_reg <= 1'b0;
        end else if (step) begin
            q_reg   <= up ? q_up : q_down;
            tc_reg  <= wrap;
            ovf_reg <= ovf_reg | wrap;
        end else begin
            tc_reg <= 1'b0;
        end
    end

    assign q   = q_reg;
    assign tc  = tc_reg;
    assign ovf = ovf_reg;

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
Parametrised successor to the fixed 4-bit free-running counter. Provides a modulo-(MAX_COUNT+1) up/down counter with enable, a prescaler, synchronous clear, and parallel load. It also provides a registered terminal-count pulse and a sticky wrap flag. It is the general counting primitive for timers, dividers and display scanning in the top-level designs.

Parameters:
WIDTH, 4, counter width in bits; q range is 0..MAX_COUNT.
MAX_COUNT, 15, highest count value; must be ≤ 2^WIDTH-1 and ≥ 1.
PRESCALE, 1, enabled clock cycles per count step; 1 means step every enabled cycle; must be ≥ 1.
PS_WIDTH, 8, prescaler register width; must satisfy 2^PS_WIDTH ≥ PRESCALE.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rs  input  1  asynchronous active-low reset (rs=0 resets immediately, released synchronously by the driver).
en  input  1  count enable; gates the prescaler and stepping.
up  input  1  direction: 1 counts up, 0 counts down; sampled at each step.
clr  input  1  synchronous clear.
load  input  1  synchronous parallel load.
d  input  WIDTH  load value.
q  output  WIDTH  current count, registered.
tc  output  1  one-cycle registered pulse on wrap.
ovf  output  1  sticky wrap flag.

Behaviour:
- Reset (rs=0, asynchronous): q=0, prescaler=0, tc=0, ovf=0. Outputs hold these values while rs=0.
- Per-edge priority: clr > load > step > hold.
- clr=1: q=0, prescaler=0, tc=0, ovf=0. Ignores load and en.
- load=1 (clr=0): q=d if d ≤ MAX_COUNT, else q=MAX_COUNT (saturate). Prescaler=0, tc=0, ovf unchanged. Works regardless of en.
- Prescaler: when en=1 and there is no clr/load, the prescaler increments. When it equals PRESCALE-1 and en=1, a step occurs and the prescaler returns to 0. When en=0, the prescaler and q hold.
- Step up: q=MAX_COUNT→0 (wrap), otherwise q+1.
- Step down: q=0→MAX_COUNT (wrap), otherwise q-1.
- Wrap step: tc=1 for exactly that one following cycle; ovf set to 1 and held until clr or rs.
- tc=0 on every non-wrap cycle, including held, loaded and cleared cycles.
- Latency: q, tc and ovf change on the edge at which the step, load or clear is sampled. There are no combinational input-to-output paths.
- A change of up takes effect at the next step. The prescaler phase is not disturbed by a direction change.
- With PRESCALE=1, stepping occurs on every cycle with en=1. The prescaler register stays 0.
- All arithmetic is WIDTH bits. q never holds a value > MAX_COUNT, including after load.
- Reset mid-prescale or mid-count discards all state. After release, the first step needs a full PRESCALE enabled cycles.

Test Plan:
- Defaults, rs pulsed low 1 ns then high, en=1, up=1 for 20 cycles -> q: 0,1,…,15,0,1,2,3. tc high only for the cycle where q=0 after 15. ovf=1 from that edge onward.
- MAX_COUNT=9, up=0, from reset -> first step q=9 with tc pulse. Then 8,7,…,0,9. A second tc pulse occurs. ovf stays 1.
- PRESCALE=4, en=1 -> q increments every 4th edge (q=1 at edge 4, 2 at edge 8). Holding en=0 for 3 cycles mid-phase delays the next step by exactly 3 cycles.
- load=1, d=12, MAX_COUNT=9 -> q=9 (saturated), tc=0. Then load and clr asserted together with q=5 -> q=0, ovf=0 (clr wins).
- rs=0 asserted asynchronously between clock edges while q=7, ovf=1 -> q=0, ovf=0, tc=0 immediately, without a clock edge. They stay 0 until rs=1 and the next step.
- Direction flip at q=0 (up 1→0 on the same edge as a step) -> q=MAX_COUNT with tc=1. Prescaler phase unchanged.
